// File: rtl/cpu_vec_pkg.sv
// cpu_vec_pkg: shared vector-path widths and vector sequencer state encoding
package cpu_vec_pkg;
    localparam int LANE_W = 16;
    localparam int VEC_W = 128;
    localparam int BEATS_DEFAULT = 8;
    typedef enum logic [2:0] {IDLE, LOAD, LOAD_DRAIN, STORE, DONE} vseq_state_t;
endpackage

// File: rtl/vector_memory_sequencer.sv
// vector_memory_sequencer: splits 128-bit vector loads/stores into 16-bit beats on the data memory port
module vector_memory_sequencer
    import cpu_vec_pkg::*;
#(
    parameter int BEATS = BEATS_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_load,
    input  logic              start_store,
    input  logic              flush,
    input  logic [LANE_W-1:0] base_addr,
    input  logic [VEC_W-1:0]  store_vector,
    input  logic [LANE_W-1:0] mem_rdata,
    output logic [LANE_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [LANE_W-1:0] mem_wdata,
    output logic              stall,
    output logic              busy,
    output logic              done,
    output logic [VEC_W-1:0]  vector_out,
    output logic              err
);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    vseq_state_t       state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cap_idx;
    logic              cap_vld;
    logic [LANE_W-1:0] base_q;
    logic [VEC_W-1:0]  vec_q;
    logic              ready;
    logic              accept;
    logic              xfer;

    assign ready     = state == IDLE || state == DONE;
    assign accept    = ready && (start_load || start_store) && !flush;
    assign busy      = !ready;
    assign xfer      = state == LOAD || state == STORE;
    // the request term is combinational, so it must not leak out while reset is held
    assign stall     = (accept && reset) || busy;
    assign done      = state == DONE;
    assign mem_addr  = xfer ? base_q + LANE_W'(cnt) : '0;
    assign mem_we    = state == STORE && !flush;
    assign mem_wdata = state == STORE ? vec_q[cnt*LANE_W +: LANE_W] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            cap_idx    <= '0;
            cap_vld    <= 1'b0;
            base_q     <= '0;
            vec_q      <= '0;
            vector_out <= '0;
            err        <= 1'b0;
        end else begin
            err     <= accept && start_load && start_store;
            // read data lags the issued address by one cycle, so the lane index is delayed to match
            cap_vld <= state == LOAD && !flush;
            cap_idx <= cnt;
            if (cap_vld)
                vector_out[cap_idx*LANE_W +: LANE_W] <= mem_rdata;
            if (flush) begin
                state <= IDLE;
            end else if (accept) begin
                state  <= start_load ? LOAD : STORE;
                cnt    <= '0;
                base_q <= base_addr;
                vec_q  <= store_vector;
            end else begin
                case (state)
                    LOAD: begin
                        cnt   <= cnt + 1'b1;
                        state <= cnt == LAST ? LOAD_DRAIN : LOAD;
                    end
                    LOAD_DRAIN: state <= DONE;
                    STORE: begin
                        cnt   <= cnt + 1'b1;
                        state <= cnt == LAST ? DONE : STORE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_vector_memory_sequencer.sv
// tb_vector_memory_sequencer: table-driven load/store transfers with a per-beat scoreboard plus flush/reset sequences
module tb_vector_memory_sequencer;
    import cpu_vec_pkg::*;
    localparam int BEATS = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start_load = 1'b0;
    logic              start_store = 1'b0;
    logic              flush = 1'b0;
    logic [15:0]       base_addr = '0;
    logic [VEC_W-1:0]  store_vector = '0;
    logic [15:0]       mem_rdata;
    logic [15:0]       mem_addr;
    logic              mem_we;
    logic [15:0]       mem_wdata;
    logic              stall;
    logic              busy;
    logic              done;
    logic [VEC_W-1:0]  vector_out;
    logic              err;

    int total = 0;
    int bad = 0;

    logic [15:0] ram [0:65535];
    logic        pl_we = 1'b0;
    logic [15:0] pl_addr = '0;
    logic [15:0] pl_data = '0;
    int          writes = 0;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
    } beat_t;
    beat_t q[$];

    typedef struct {
        logic             ld;
        logic             st;
        logic [15:0]      base;
        logic [VEC_W-1:0] sv;
        logic [VEC_W-1:0] ev;
        int               edone;
        logic             eerr;
        logic             poke;
    } vec_t;
    vec_t tv[5];

    vector_memory_sequencer #(.BEATS(BEATS)) dut (
        .clk(clk), .reset(reset), .start_load(start_load), .start_store(start_store),
        .flush(flush), .base_addr(base_addr), .store_vector(store_vector),
        .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .stall(stall), .busy(busy), .done(done), .vector_out(vector_out), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            writes <= writes + 1;
        end else if (pl_we) begin
            ram[pl_addr] <= pl_data;
        end
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        pl_we = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic run(input logic ld, input logic st, input logic [15:0] base,
                       input logic [VEC_W-1:0] sv, input logic [VEC_W-1:0] ev,
                       input int edone, input logic eerr, input logic poke);
        int    stalls = 1;
        int    dcyc = -1;
        logic  eseen = 1'b0;
        logic  we_exp = st && !ld;
        beat_t b;
        start_load = ld;
        start_store = st;
        base_addr = base;
        store_vector = sv;
        for (int k = 0; k < BEATS; k++)
            q.push_back(beat_t'{base + 16'(k), we_exp, we_exp ? sv[16*k +: 16] : 16'h0});
        #1 chk("stall_on_request", 128'(stall), 128'(1));
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (stall) stalls++;
            if (done && dcyc < 0) dcyc = c;
            if (err) eseen = 1'b1;
            if (c <= BEATS && q.size() > 0) begin
                b = q.pop_front();
                chk($sformatf("beat%0d", c - 1), 128'({mem_addr, mem_we, mem_wdata}),
                    128'({b.addr, b.we, b.wdata}));
            end else if (mem_we) begin
                chk("stray_write", 128'(mem_we), 128'(0));
            end
            start_load = poke && c == 3 && !ld;
            start_store = poke && c == 3 && ld;
        end
        chk("stall_cycles", 128'(stalls), 128'(edone));
        chk("done_cycle", 128'(dcyc), 128'(edone));
        chk("err_pulse", 128'(eseen), 128'(eerr));
        chk("queue_empty", 128'(q.size()), 128'(0));
        if (ld) chk("vector_out", vector_out, ev);
    endtask

    initial begin
        logic [VEC_W-1:0] lv100, lvfffe, sv40, svc, evp;
        int w0;
        logic dn;
        for (int k = 0; k < BEATS; k++) begin
            lv100[16*k +: 16]  = 16'(16'h1110 * (k + 1));
            lvfffe[16*k +: 16] = 16'(16'h5000 + k);
            sv40[16*k +: 16]   = 16'(16'hA000 + k);
            svc[16*k +: 16]    = 16'(16'hC000 + k);
            evp[16*k +: 16]    = k < 3 ? 16'(16'hC000 + k) : 16'h0BAD;
        end
        tv[0] = '{1'b1, 1'b0, 16'h0100, '0,   lv100,  10, 1'b0, 1'b0};
        tv[1] = '{1'b0, 1'b1, 16'h0040, sv40, '0,     9,  1'b0, 1'b1};
        tv[2] = '{1'b1, 1'b0, 16'hFFFE, '0,   lvfffe, 10, 1'b0, 1'b0};
        tv[3] = '{1'b1, 1'b1, 16'h0100, sv40, lv100,  10, 1'b1, 1'b0};
        tv[4] = '{1'b1, 1'b0, 16'h0040, '0,   sv40,   10, 1'b0, 1'b1};

        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ctl", 128'({stall, busy, done, err, mem_we, mem_addr, mem_wdata}), 128'(0));
        chk("reset_vec", vector_out, '0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_outputs", 128'({stall, busy, done, err, mem_we, mem_addr, mem_wdata}), 128'(0));

        for (int k = 0; k < BEATS; k++) begin
            preload(16'(16'h0100 + k), lv100[16*k +: 16]);
            preload(16'(16'hFFFE + k), lvfffe[16*k +: 16]);
            preload(16'(16'h0200 + k), 16'h0BAD);
        end

        for (int i = 0; i < 5; i++)
            run(tv[i].ld, tv[i].st, tv[i].base, tv[i].sv, tv[i].ev, tv[i].edone, tv[i].eerr, tv[i].poke);

        w0 = writes;
        start_store = 1'b1;
        base_addr = 16'h0200;
        store_vector = svc;
        @(negedge clk);
        start_store = 1'b0;
        repeat (3) @(negedge clk);
        chk("store_beat3_pre", 128'({mem_we, mem_addr}), 128'({1'b1, 16'h0203}));
        flush = 1'b1;
        #1 chk("flush_gates_we", 128'(mem_we), 128'(0));
        @(negedge clk);
        dn = done;
        chk("idle_after_flush", 128'({busy, stall, mem_we, mem_addr}), 128'(0));
        flush = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done) dn = 1'b1;
        end
        chk("no_done_after_flush", 128'(dn), 128'(0));
        chk("writes_before_flush", 128'(writes - w0), 128'(3));
        run(1'b1, 1'b0, 16'h0200, '0, evp, 10, 1'b0, 1'b0);

        start_load = 1'b1;
        base_addr = 16'h0100;
        @(negedge clk);
        start_load = 1'b0;
        repeat (5) @(negedge clk);
        chk("busy_beat5", 128'({busy, mem_addr}), 128'({1'b1, 16'h0105}));
        reset = 1'b0;
        #1 chk("midload_reset_ctl", 128'({stall, busy, done, err, mem_we, mem_addr, mem_wdata}), 128'(0));
        chk("midload_reset_vec", vector_out, '0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run(1'b1, 1'b0, 16'h0100, '0, lv100, 10, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vector_memory_sequencer.md
VECTOR_MEMORY_SEQUENCER -- requirements
Module: vector_memory_sequencer

Interface
REQ-001 The block SHALL have one parameter: BEATS, default 8, the number of 16-bit beats per 128-bit vector transfer.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low (ports named clk and reset as elsewhere in the CPU core; polarity and synchronicity fixed).
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 start_load  in  1  MEM-stage vector load request.
REQ-006 start_store  in  1  MEM-stage vector store request.
REQ-007 flush  in  1  pipeline flush; aborts any transfer in progress.
REQ-008 base_addr  in  16  word address of lane 0.
REQ-009 store_vector  in  128  store data; lane k = bits [16k+15:16k].
REQ-010 mem_rdata  in  16  data memory read data; synchronous RAM, one-cycle read latency.
REQ-011 mem_addr  out  16  data memory word address.
REQ-012 mem_we  out  1  data memory write enable.
REQ-013 mem_wdata  out  16  data memory write data.
REQ-014 stall  out  1  holds IF/ID/EX/MEM stages and the MEM/WB register inputs.
REQ-015 busy  out  1  high in any state other than IDLE or DONE.
REQ-016 done  out  1  one-cycle pulse on transfer completion.
REQ-017 vector_out  out  128  assembled load vector, sent to vector_data_from_memory_in of the MEM/WB register.
REQ-018 err  out  1  one-cycle pulse when start_load and start_store are both accepted in the same cycle.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, LOAD_DRAIN, STORE and DONE.
REQ-020 A request SHALL be accepted only in IDLE or DONE; at acceptance, base_addr and store_vector are registered and the beat counter is cleared.
REQ-021 start_load with start_store SHALL select the load, ignore the store and pulse err.
REQ-022 stall SHALL equal (IDLE or DONE) with (start_load or start_store) and not flush, OR state in {LOAD, LOAD_DRAIN, STORE}.
REQ-023 LOAD SHALL last BEATS cycles, driving mem_addr = base+k on beat k with mem_we=0.
REQ-024 Data returned for beat k SHALL be written to vector_out lane k on the clock edge following the issue of beat k.
REQ-025 LOAD_DRAIN SHALL last one cycle to capture the last beat, then go to DONE.
REQ-026 For a load accepted in cycle T: addresses issue in T+1..T+8, done=1 in T+10, and vector_out is stable from T+10 until the next load capture.
REQ-027 STORE SHALL last BEATS cycles with mem_we=1, mem_addr = base+k and mem_wdata = lane k; it then goes to DONE (done in T+9).
REQ-028 DONE SHALL last one cycle with stall=0 and busy=0, and return to IDLE unless a new request is accepted.
REQ-029 Address arithmetic SHALL be modulo 2^16 (base 16'hFFFE wraps to 0000..0005).
REQ-030 flush SHALL gate mem_we to 0 in the same cycle, force IDLE on the next edge and suppress done; beats already written remain; vector_out keeps partially written lanes.
REQ-031 Requests arriving while busy SHALL be ignored.
REQ-032 When idle, mem_addr SHALL be 0, mem_we 0 and mem_wdata 0.

Reset
REQ-033 Asserting reset at any time, including mid-transfer, SHALL force IDLE, clear the counter, vector_out and captured registers, and drive all outputs to 0.

Structure
REQ-034 Shared package cpu_vec_pkg SHALL hold LANE_W=16, VEC_W=128, the default BEATS and the state enum typedef.
REQ-035 The block SHALL need no sub-module; it consists of the FSM, a 3-bit beat counter, a lane-capture register, a store-data register and an address adder.

Verification
REQ-036 Load at base 0x0100 with RAM[0x100+k]=0x1110*(k+1) -> stall for 10 cycles, done in T+10, vector_out lane k = 0x1110*(k+1).
REQ-037 Store at base 0x0040 with store_vector lanes 0xA000+k -> 8 writes to 0x0040..0x0047, mem_we high T+1..T+8, done in T+9.
REQ-038 Load at base 0xFFFE -> addresses FFFE, FFFF, 0000..0005 in order.
REQ-039 start_load and start_store in the same cycle -> err pulse, load sequence runs, no mem_we.
REQ-040 flush asserted during STORE beat 3 -> mem_we=0 in that cycle, only beats 0..2 written, IDLE next cycle, no done.
REQ-041 reset asserted during LOAD beat 5 -> all outputs 0 immediately; a load after reset release completes normally.
